// File: rtl/job_fifo_pkg.sv
// Shared definitions for the job FIFO drain path.
// Holds control-lane bit positions and the reader FSM states.
package job_fifo_pkg;

  localparam int CB_SOJ     = 5;
  localparam int CB_EOJ     = 4;
  localparam int CB_BCNT_HI = 3;
  localparam int CB_BCNT_LO = 0;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DISCARD
  } state_t;

endpackage

// File: rtl/job_fifo_reader_if.sv
// FIFO-head and PHY-transmit signal bundle for the job reader.
// master: reader side; slave: FIFO/PHY side.
interface job_fifo_reader_if #(
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 6
);
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_r_data_d;
  logic [CWIDTH-1:0] fifo_r_data_c;
  logic              fifo_rd;
  logic              tx_valid;
  logic              tx_ready;
  logic [DWIDTH-1:0] tx_data_d;
  logic [CWIDTH-1:0] tx_data_c;

  modport master (
    input  fifo_empty,
    input  fifo_r_data_d,
    input  fifo_r_data_c,
    output fifo_rd,
    output tx_valid,
    input  tx_ready,
    output tx_data_d,
    output tx_data_c
  );

  modport slave (
    output fifo_empty,
    output fifo_r_data_d,
    output fifo_r_data_c,
    input  fifo_rd,
    input  tx_valid,
    output tx_ready,
    input  tx_data_d,
    input  tx_data_c
  );
endinterface

// File: rtl/job_tx_stage.sv
// One-entry registered output slot with valid/ready hold.
// Ports: load/din_* fill, force_eoj sets EOJ, valid/dout_* drain on ready.
module job_tx_stage
  import job_fifo_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              force_eoj,
  input  logic              ready,
  input  logic [DWIDTH-1:0] din_d,
  input  logic [CWIDTH-1:0] din_c,
  output logic              valid,
  output logic [DWIDTH-1:0] dout_d,
  output logic [CWIDTH-1:0] dout_c
);

  logic [CWIDTH-1:0] c_in;

  always_comb begin
    c_in = din_c;
    c_in[CB_EOJ] = din_c[CB_EOJ] | force_eoj;
  end

  // Load has priority: the reader only loads when the slot
  // is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid  <= 1'b0;
      dout_d <= '0;
      dout_c <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      dout_d <= din_d;
      dout_c <= c_in;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/job_fifo_reader.sv
// Job FIFO drain: pops words, checks SOJ/EOJ framing, feeds the PHY.
// Ports: clk, reset, bus (FIFO head + tx), netfin, err_*, job_cnt.
module job_fifo_reader
  import job_fifo_pkg::*;
#(
  parameter int DWIDTH        = 64,
  parameter int CWIDTH        = 6,
  parameter int MAX_JOB_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  job_fifo_reader_if.master  bus,
  output logic               netfin,
  output logic               err_orphan,
  output logic               err_trunc,
  output logic               err_long,
  output logic [31:0]        job_cnt
);

  localparam int WW = $clog2(MAX_JOB_WORDS + 1);

  state_t        state, state_nx;
  logic [WW-1:0] wcnt, wcnt_nx, wcnt_inc;
  logic          slot_free, head, soj, eoj;
  logic          pop, load, force_eoj;
  logic          orphan_nx, trunc_nx, long_nx;
  logic          tx_hs;

  assign slot_free = ~bus.tx_valid | bus.tx_ready;
  assign head      = reset & ~bus.fifo_empty;
  assign soj       = bus.fifo_r_data_c[CB_SOJ];
  assign eoj       = bus.fifo_r_data_c[CB_EOJ];
  assign wcnt_inc  = (&wcnt) ? wcnt : wcnt + 1'b1;
  assign tx_hs     = bus.tx_valid & bus.tx_ready;
  assign bus.fifo_rd = pop;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    pop       = 1'b0;
    load      = 1'b0;
    force_eoj = 1'b0;
    orphan_nx = 1'b0;
    trunc_nx  = 1'b0;
    long_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        pop = head & slot_free;
        if (pop && soj) begin
          load     = 1'b1;
          wcnt_nx  = WW'(1);
          state_nx = eoj ? IDLE : ACTIVE;
        end else if (pop) begin
          orphan_nx = 1'b1;
        end
      end
      ACTIVE: begin
        pop  = head & slot_free;
        load = pop;
        if (pop && soj) begin
          trunc_nx = 1'b1;
          wcnt_nx  = WW'(1);
          state_nx = eoj ? IDLE : ACTIVE;
        end else if (pop && eoj) begin
          wcnt_nx  = wcnt_inc;
          state_nx = IDLE;
        end else if (pop &&
                     wcnt == WW'(MAX_JOB_WORDS - 1)) begin
          force_eoj = 1'b1;
          long_nx   = 1'b1;
          wcnt_nx   = wcnt_inc;
          state_nx  = DISCARD;
        end else if (pop) begin
          wcnt_nx = wcnt_inc;
        end
      end
      DISCARD: begin
        // Dropped words need no slot; an SOJ word restarts
        // a job and must wait for the output slot.
        pop = head & (slot_free | ~soj);
        if (pop && soj) begin
          load     = 1'b1;
          wcnt_nx  = WW'(1);
          state_nx = eoj ? IDLE : ACTIVE;
        end else if (pop && eoj) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt       <= '0;
      netfin     <= 1'b0;
      err_orphan <= 1'b0;
      err_trunc  <= 1'b0;
      err_long   <= 1'b0;
      job_cnt    <= '0;
    end else begin
      wcnt       <= wcnt_nx;
      netfin     <= tx_hs & bus.tx_data_c[CB_EOJ];
      err_orphan <= orphan_nx;
      err_trunc  <= trunc_nx;
      err_long   <= long_nx;
      if (tx_hs && bus.tx_data_c[CB_EOJ])
        job_cnt <= job_cnt + 32'd1;
    end
  end

  job_tx_stage #(
    .DWIDTH (DWIDTH),
    .CWIDTH (CWIDTH)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .force_eoj (force_eoj),
    .ready     (bus.tx_ready),
    .din_d     (bus.fifo_r_data_d),
    .din_c     (bus.fifo_r_data_c),
    .valid     (bus.tx_valid),
    .dout_d    (bus.tx_data_d),
    .dout_c    (bus.tx_data_c)
  );

endmodule

// File: tb/tb_job_fifo_reader.sv
// Scoreboard bench for job_fifo_reader (MAX_JOB_WORDS=4).
// FIFO and PHY are modelled here; outputs sampled on negedge.
module tb_job_fifo_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        netfin, err_orphan, err_trunc, err_long;
  logic [31:0] job_cnt;

  job_fifo_reader_if #(.DWIDTH(64), .CWIDTH(6)) bus ();

  job_fifo_reader #(
    .DWIDTH        (64),
    .CWIDTH        (6),
    .MAX_JOB_WORDS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .netfin     (netfin),
    .err_orphan (err_orphan),
    .err_trunc  (err_trunc),
    .err_long   (err_long),
    .job_cnt    (job_cnt)
  );

  always #5 clk = ~clk;

  logic [69:0] fifo_q[$];
  logic [69:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int netfin_n = 0, orphan_n = 0, trunc_n = 0, long_n = 0;
  int e_netfin = 0, e_orphan = 0, e_trunc = 0, e_long = 0;
  int e_jobs = 0;
  logic rd_seen = 1'b0;
  logic stall_chk = 1'b0;
  logic hold_pend = 1'b0;
  logic [63:0] hold_d;
  logic [5:0]  hold_c;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive_head();
    bus.fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) begin
      bus.fifo_r_data_c = fifo_q[0][69:64];
      bus.fifo_r_data_d = fifo_q[0][63:0];
    end else begin
      bus.fifo_r_data_c = '0;
      bus.fifo_r_data_d = '0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() != 0)
      void'(fifo_q.pop_front());
    drive_head();
  endtask

  task automatic push(input logic [5:0] c,
                      input bit emit,
                      input bit force_e);
    logic [63:0] d;
    logic [5:0]  ce;
    d = {$urandom, $urandom};
    fifo_q.push_back({c, d});
    ce = c;
    if (force_e) ce[4] = 1'b1;
    if (emit) exp_q.push_back({ce, d});
    drive_head();
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0)
           && i < budget) begin
      cyc();
      i++;
    end
    chk("drain_left", fifo_q.size() + exp_q.size(), 0);
    fifo_q.delete();
    exp_q.delete();
    drive_head();
    repeat (3) cyc();
  endtask

  task automatic tally(input string tag);
    chk({tag, "_netfin"}, netfin_n, e_netfin);
    chk({tag, "_orphan"}, orphan_n, e_orphan);
    chk({tag, "_trunc"},  trunc_n,  e_trunc);
    chk({tag, "_long"},   long_n,   e_long);
    @(negedge clk);
    chk({tag, "_jobs"},   job_cnt,  e_jobs);
  endtask

  always @(negedge clk) begin
    logic [69:0] e;
    rd_seen = bus.fifo_rd;
    if (!reset) chk("rd_in_reset", bus.fifo_rd, 0);
    if (hold_pend) begin
      chk("hold_v", bus.tx_valid, 1);
      chk("hold_d", bus.tx_data_d, hold_d);
      chk("hold_c", bus.tx_data_c, hold_c);
    end
    hold_pend = reset && bus.tx_valid && !bus.tx_ready;
    hold_d = bus.tx_data_d;
    hold_c = bus.tx_data_c;
    if (stall_chk && bus.tx_valid && !bus.tx_ready)
      chk("rd_stall", bus.fifo_rd, 0);
    if (reset && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("tx_extra", bus.tx_data_c, 6'h3f);
      end else begin
        e = exp_q.pop_front();
        chk("tx_d", bus.tx_data_d, e[63:0]);
        chk("tx_c", bus.tx_data_c, e[69:64]);
      end
    end
    if (netfin)     netfin_n++;
    if (err_orphan) orphan_n++;
    if (err_trunc)  trunc_n++;
    if (err_long)   long_n++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bus.tx_ready = 1'b1;
    drive_head();
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_valid",  bus.tx_valid, 0);
    chk("rst_data_d", bus.tx_data_d, 0);
    chk("rst_data_c", bus.tx_data_c, 0);
    chk("rst_netfin", netfin, 0);
    chk("rst_errs", {err_orphan, err_trunc, err_long}, 0);
    chk("rst_jobs", job_cnt, 0);
    cyc();
    reset = 1'b1;
    repeat (2) cyc();

    // Three-word job, back-to-back, one-cycle latency.
    push(6'h28, 1, 0);
    push(6'h08, 1, 0);
    push(6'h18, 1, 0);
    @(negedge clk);
    chk("t1_rd", bus.fifo_rd, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk("t1_valid", bus.tx_valid, 1);
    end
    drain(20);
    e_netfin += 1; e_jobs += 1;
    tally("t1");

    // Single-word job then an orphan.
    push(6'h38, 1, 0);
    push(6'h08, 0, 0);
    drain(20);
    e_netfin += 1; e_orphan += 1; e_jobs += 1;
    tally("t2");

    // Over-long job, forced EOJ, tail discarded.
    push(6'h28, 1, 0);
    push(6'h08, 1, 0);
    push(6'h08, 1, 0);
    push(6'h08, 1, 1);
    push(6'h08, 0, 0);
    push(6'h18, 0, 0);
    push(6'h38, 1, 0);
    drain(40);
    e_netfin += 2; e_long += 1; e_jobs += 2;
    tally("t3");

    // Over-long job, SOJ while discarding restarts.
    push(6'h21, 1, 0);
    push(6'h02, 1, 0);
    push(6'h03, 1, 0);
    push(6'h04, 1, 1);
    push(6'h05, 0, 0);
    push(6'h28, 1, 0);
    push(6'h17, 1, 0);
    drain(40);
    e_netfin += 2; e_long += 1; e_jobs += 2;
    tally("t3b");

    // Stalls with ready pattern 1,0,0,1.
    push(6'h28, 1, 0);
    push(6'h08, 1, 0);
    push(6'h08, 1, 0);
    push(6'h18, 1, 0);
    stall_chk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.tx_ready = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
      cyc();
    end
    bus.tx_ready = 1'b1;
    drain(20);
    stall_chk = 1'b0;
    e_netfin += 1; e_jobs += 1;
    tally("t4");

    // SOJ at word 2 truncates the open job.
    push(6'h28, 1, 0);
    push(6'h28, 1, 0);
    push(6'h08, 1, 0);
    push(6'h18, 1, 0);
    drain(20);
    e_netfin += 1; e_trunc += 1; e_jobs += 1;
    tally("t5");

    // Reset while ACTIVE with a stalled output word.
    bus.tx_ready = 1'b0;
    push(6'h28, 0, 0);
    push(6'h08, 0, 0);
    push(6'h08, 0, 0);
    repeat (3) cyc();
    @(negedge clk);
    chk("t6_pre_valid", bus.tx_valid, 1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rd_rst", bus.fifo_rd, 0);
    cyc();
    @(negedge clk);
    chk("t6_valid", bus.tx_valid, 0);
    chk("t6_jobs", job_cnt, 0);
    fifo_q.delete();
    exp_q.delete();
    drive_head();
    bus.tx_ready = 1'b1;
    cyc();
    reset = 1'b1;
    e_jobs = 0;
    cyc();
    push(6'h38, 1, 0);
    drain(20);
    e_netfin += 1; e_jobs += 1;
    tally("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/job_fifo_reader.md
# job_fifo_reader

Drain side of the job FIFO buffer. Pops job words from the FIFO head, reads them first-word-fall-through with the `rd` strobe, and validates job framing on the 6-bit control lane. Drives the words to the PHY transmit path through a one-entry registered output stage with valid/ready. Signals job completion on `netfin`, force-terminates over-long jobs, and flags framing errors.

## Interface
Parameters:
- `DWIDTH`, 64: data lane width.
- `CWIDTH`, 6: control lane width.
- `MAX_JOB_WORDS`, 256: maximum words per job before forced termination.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_data_d`  in  DWIDTH  FIFO head data, valid combinationally when `fifo_empty`=0.
- `fifo_r_data_c`  in  CWIDTH  FIFO head control: [5]=SOJ, [4]=EOJ, [3:0]=valid byte count (1..8).
- `fifo_rd`  out  1  pop strobe; head advances at clock edge.
- `tx_valid`  out  1  output word valid.
- `tx_ready`  in  1  downstream accepts when high with `tx_valid`.
- `tx_data_d`  out  DWIDTH  output data.
- `tx_data_c`  out  CWIDTH  output control, same encoding as input.
- `netfin`  out  1  one-cycle pulse: an EOJ word was accepted downstream.
- `err_orphan`  out  1  pulse: a non-SOJ word was popped in IDLE.
- `err_trunc`  out  1  pulse: an SOJ word arrived in ACTIVE.
- `err_long`  out  1  pulse: a job hit `MAX_JOB_WORDS` without EOJ.
- `job_cnt`  out  32  count of completed jobs; wraps.

## Operation
- `slot_free = ~tx_valid | tx_ready`.
- In IDLE and ACTIVE: `fifo_rd = reset & ~fifo_empty & slot_free`. A pop loads the head into the output register.
- In DISCARD: `fifo_rd = reset & ~fifo_empty`. Popped words are dropped.
- `fifo_rd` is never high while `reset`=0.

States:
- IDLE:
  - Popped word with SOJ is emitted. `wcnt` becomes 1.
  - If the word also has EOJ, stay in IDLE (single-word job). Otherwise go to ACTIVE.
  - Popped word without SOJ is dropped and pulses `err_orphan`.
- ACTIVE: each popped word is emitted and increments `wcnt`.
  - EOJ word: go to IDLE.
  - SOJ word: pulse `err_trunc`. The word starts a new job; `wcnt`=1; stay in ACTIVE, or go to IDLE if it also has EOJ. No `netfin` is produced for the truncated job.
  - Non-EOJ word when `wcnt` = `MAX_JOB_WORDS`-1: emit it with EOJ forced to 1, pulse `err_long`, go to DISCARD.
- DISCARD: drop words until an EOJ word is popped, then go to IDLE.
  - An SOJ word in DISCARD is not dropped. It is handled exactly as in IDLE.
- Underrun: FIFO empty mid-job inserts bubbles (`tx_valid`=0). This is not an error.
- `netfin` and the `job_cnt` increment occur on the output handshake of a word with `tx_data_c[4]`=1, including forced EOJ words.
- `wcnt` width is `$clog2(MAX_JOB_WORDS+1)`. `wcnt` saturates and never wraps.

## Timing
- Head present and `slot_free` in cycle N: `fifo_rd`=1 in cycle N, and the word is on `tx_*` with `tx_valid`=1 in cycle N+1.
- Throughput is 1 word/cycle while `tx_ready`=1.
- `tx_data_*` stay stable while `tx_valid`=1 and `tx_ready`=0.
- `netfin` is registered: high in cycle N+1 after the handshake in cycle N.
- `err_*` are registered and pulse in the cycle after the offending pop.
- Reset values (applied at the first edge with `reset`=0):
  - state IDLE
  - `tx_valid`=0, `tx_data_d`=0, `tx_data_c`=0
  - `netfin`=0, all `err_*`=0
  - `job_cnt`=0, `wcnt`=0
- Reset mid-job drops the in-flight output word. There is no `netfin` for it.

## Structure
- Package `job_fifo_pkg` holds:
  - control bit positions `CB_SOJ`=5, `CB_EOJ`=4, `CB_BCNT`=3:0;
  - the state enum {IDLE, ACTIVE, DISCARD}.
- One sub-module, `job_tx_stage`: the one-entry output register with valid/ready hold, load, and forced-EOJ input. The FSM, counters and pop logic live in `job_fifo_reader`.

## Test plan
- Job of 3 words (c = 0x28, 0x08, 0x18), `tx_ready`=1 → words emitted back-to-back, 1-cycle latency; `netfin` pulses once; `job_cnt`=1.
- Single word c=0x38 followed by orphan c=0x08 → first word emitted with `netfin`; second word dropped; `err_orphan`=1 one cycle.
- `MAX_JOB_WORDS`=4, job of 6 words then a new SOJ job → 4 words out, the 4th with c[4]=1; `err_long` pulses; 2 words dropped; the next job is emitted normally.
- 4-word job with `tx_ready` toggling 1,0,0,1 → `tx_data_*` held during stall; no loss or duplication; `fifo_rd` low while stalled.
- SOJ arriving at word 2 of an open job → `err_trunc` pulses; new job emitted; `netfin` only for the new job's EOJ; `job_cnt` +1.
- `reset`=0 while ACTIVE with `tx_valid`=1 → next cycle `tx_valid`=0, state IDLE, `job_cnt`=0, `fifo_rd`=0 throughout reset.
